// File: rtl/cdb_arbiter.sv
// cdb_arbiter: collects results from four functional units (ALU, MULT, MEM, BR)
// into one-entry hold buffers and broadcasts one per cycle on the common data bus.
// Latency: a result accepted in cycle N reaches the CDB in cycle N+2 if it wins at once.
// Backpressure: fu_ready[i] drops while hold[i] is occupied and not being granted.
// Ports:
//   clk, rst (sync, active-high), flush (discard held/in-flight results)
//   fu_valid/fu_ready handshake per FU, with fu_rd_s / fu_rd_v / fu_rob_idx payload
//   CDB_valid, CDB_regf_we, CDB_rd_s, CDB_rd_v, CDB_rob_idx broadcast outputs
module cdb_arbiter #(
  parameter int PHYS_REG_IDX = 5,
  parameter int ROB_IDX_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [3:0]              fu_valid,
  output logic [3:0]              fu_ready,
  input  logic [PHYS_REG_IDX:0]   fu_rd_s    [4],
  input  logic [31:0]             fu_rd_v    [4],
  input  logic [ROB_IDX_W-1:0]    fu_rob_idx [4],
  output logic                    CDB_valid,
  output logic                    CDB_regf_we,
  output logic [PHYS_REG_IDX:0]   CDB_rd_s,
  output logic [31:0]             CDB_rd_v,
  output logic [ROB_IDX_W-1:0]    CDB_rob_idx
);

  logic [3:0]            hold_valid;
  logic [PHYS_REG_IDX:0] hold_rd_s    [4];
  logic [31:0]           hold_rd_v    [4];
  logic [ROB_IDX_W-1:0]  hold_rob_idx [4];
  logic [1:0]            rr_ptr;

  logic [3:0] grant;
  logic [1:0] win;
  logic [1:0] idx;
  logic       any_grant;

  // Round-robin search starting at rr_ptr; the 2-bit index wraps modulo 4.
  always_comb begin
    any_grant = 1'b0;
    win       = rr_ptr;
    idx       = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!any_grant && hold_valid[idx] && !flush) begin
        any_grant = 1'b1;
        win       = idx;
      end
    end
    grant = any_grant ? (4'b0001 << win) : 4'b0000;
  end

  // A slot being granted this cycle frees up in time to take a new result,
  // which is what lets a single FU stream back-to-back without bubbles.
  always_comb begin
    fu_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      fu_ready[i] = !flush && (!hold_valid[i] || grant[i]);
    end
  end

  assign CDB_regf_we = CDB_valid && (CDB_rd_s != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid  <= 4'b0000;
      rr_ptr      <= 2'd0;
      CDB_valid   <= 1'b0;
      CDB_rd_s    <= '0;
      CDB_rd_v    <= '0;
      CDB_rob_idx <= '0;
      for (int i = 0; i < 4; i++) begin
        hold_rd_s[i]    <= '0;
        hold_rd_v[i]    <= '0;
        hold_rob_idx[i] <= '0;
      end
    end else if (flush) begin
      // CDB payload is left as-is; only the valid bits are dropped.
      hold_valid <= 4'b0000;
      CDB_valid  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          hold_valid[i]   <= 1'b1;
          hold_rd_s[i]    <= fu_rd_s[i];
          hold_rd_v[i]    <= fu_rd_v[i];
          hold_rob_idx[i] <= fu_rob_idx[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      CDB_valid <= any_grant;
      if (any_grant) begin
        CDB_rd_s    <= hold_rd_s[win];
        CDB_rd_v    <= hold_rd_v[win];
        CDB_rob_idx <= hold_rob_idx[win];
        rr_ptr      <= win + 2'd1;
      end
    end
  end

endmodule
